// File: rtl/shift_stage_pkg.sv
// Shared definitions for the shift command stage.
// A command is packed MSB-first as {data, amt, lr}. Its width depends on N,
// so the RTL packs it as a plain vector sized by cmd_width(). cmd_t shows the
// same layout at the default geometry.
package shift_stage_pkg;

   localparam int unsigned N_DEFAULT     = 3;
   localparam int unsigned DEPTH_DEFAULT = 4;

   typedef struct packed {
      logic [(2**N_DEFAULT)-1:0] data;
      logic [N_DEFAULT-1:0]      amt;
      logic                      lr;
   } cmd_t;

   // Width of a packed {data, amt, lr} command for a given N.
   function automatic int unsigned cmd_width(input int unsigned n);
      return (2**n) + n + 1;
   endfunction

   // Counter width able to hold 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// Command FIFO for the shift stage.
// Ports: clk, reset_n (sync, active-low); push with push_data/push_amt/push_lr;
// pop; head_data/head_amt/head_lr show the entry at rd_ptr (stale when empty);
// count, full, empty.
// The caller must not push when full or pop when empty.
module shift_cmd_fifo
   import shift_stage_pkg::*;
#(
   parameter int unsigned N     = N_DEFAULT,
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          push,
   input  logic [(2**N)-1:0]             push_data,
   input  logic [N-1:0]                  push_amt,
   input  logic                          push_lr,
   input  logic                          pop,
   output logic [(2**N)-1:0]             head_data,
   output logic [N-1:0]                  head_amt,
   output logic                          head_lr,
   output logic [cnt_width(DEPTH)-1:0]   count,
   output logic                          full,
   output logic                          empty
);

   localparam int unsigned W    = 2**N;
   localparam int unsigned CMDW = cmd_width(N);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CW   = cnt_width(DEPTH);

   logic [CMDW-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CMDW-1:0] head;

   // Storage is not reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {push_data, push_amt, push_lr};
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      head      = mem[rd_ptr];
      head_data = head[CMDW-1 -: W];
      head_amt  = head[N:1];
      head_lr   = head[0];
      full      = (count == CW'(DEPTH));
      empty     = (count == '0);
   end

endmodule

// File: rtl/shift_cmd_stage.sv
// Upstream command stage for the combinational shifter datapath.
// Ports: clk, reset_n (sync, active-low); input handshake in_valid/in_ready
// with in_data/in_amt/in_lr; shifter drive sh_a/sh_amt/sh_lr and result sh_y;
// output handshake out_valid/out_ready with out_data/out_lr; fifo_count.
// The shifter sees only the FIFO head, which holds still until it is popped,
// so its operand never changes while a result is waiting to be captured.
module shift_cmd_stage
   import shift_stage_pkg::*;
#(
   parameter int unsigned N     = N_DEFAULT,
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [(2**N)-1:0]             in_data,
   input  logic [N-1:0]                  in_amt,
   input  logic                          in_lr,
   output logic [(2**N)-1:0]             sh_a,
   output logic [N-1:0]                  sh_amt,
   output logic                          sh_lr,
   input  logic [(2**N)-1:0]             sh_y,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [(2**N)-1:0]             out_data,
   output logic                          out_lr,
   output logic [cnt_width(DEPTH)-1:0]   fifo_count
);

   logic push;
   logic pop;
   logic full;
   logic empty;

   shift_cmd_fifo #(
      .N     (N),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (in_data),
      .push_amt  (in_amt),
      .push_lr   (in_lr),
      .pop       (pop),
      .head_data (sh_a),
      .head_amt  (sh_amt),
      .head_lr   (sh_lr),
      .count     (fifo_count),
      .full      (full),
      .empty     (empty)
   );

   // Ready depends only on occupancy; a same-cycle pop does not open a slot.
   always_comb begin
      in_ready = reset_n && !full;
      push     = in_valid && in_ready;
      pop      = !empty && (!out_valid || out_ready);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_lr    <= 1'b0;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_data  <= sh_y;
         out_lr    <= sh_lr;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_cmd_stage.sv
// Bench for shift_cmd_stage: models the shifter as a rotate (lr=1 left),
// keeps a scoreboard of expected {lr, data} results and checks every output
// transfer plus directed reset/latency/backpressure/wrap/flush checks.
module tb_shift_cmd_stage;

   localparam int unsigned N     = 3;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned W     = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic [N-1:0] in_amt = '0;
   logic         in_lr = 1'b0;
   logic [W-1:0] sh_a;
   logic [N-1:0] sh_amt;
   logic         sh_lr;
   logic [W-1:0] sh_y;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic         out_lr;
   logic [2:0]   fifo_count;

   int total = 0;
   int bad   = 0;
   logic [W:0] sb[$];

   always #5 clk = ~clk;

   shift_cmd_stage #(
      .N     (N),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_amt     (in_amt),
      .in_lr      (in_lr),
      .sh_a       (sh_a),
      .sh_amt     (sh_amt),
      .sh_lr      (sh_lr),
      .sh_y       (sh_y),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_lr     (out_lr),
      .fifo_count (fifo_count)
   );

   function automatic logic [W-1:0] rot(input logic [W-1:0] d, input logic [N-1:0] a,
                                        input logic lr);
      logic [2*W-1:0] dd;
      logic [2*W-1:0] t;
      int s;
      dd = {d, d};
      s  = int'(a);
      t  = lr ? (dd >> (W - s)) : (dd >> s);
      return t[W-1:0];
   endfunction

   assign sh_y = rot(sh_a, sh_amt, sh_lr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Handshakes are stable at the falling edge; record what the next rising
   // edge will transfer.
   always @(negedge clk) begin
      if (!reset_n) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("sb_unexpected", {23'd0, out_lr, out_data}, 32'hFFFF_FFFF);
            end else begin
               check("sb_result", {23'd0, out_lr, out_data}, {23'd0, sb.pop_front()});
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back({in_lr, rot(in_data, in_amt, in_lr)});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Offer one command and hold it until accepted (bounded).
   task automatic send(input logic [W-1:0] d, input logic [N-1:0] a, input logic lr);
      logic acc;
      int   n;
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_lr    = lr;
      n = 0;
      do begin
         acc = in_ready;
         step();
         n++;
      end while (!acc && n < 50);
      if (!acc) check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset held with in_valid asserted.
      reset_n  = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_in_ready", {31'd0, in_ready}, 32'd0);
         check("rst_out_valid", {31'd0, out_valid}, 32'd0);
         check("rst_count", {29'd0, fifo_count}, 32'd0);
      end
      in_valid = 1'b0;
      reset_n  = 1'b1;
      #1;
      check("rel_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      check("rel_out_data", {24'd0, out_data}, 32'd0);

      // Single command, right shift, latency.
      out_ready = 1'b1;
      send(8'hF0, 3'd3, 1'b0);
      check("lat_e0_valid", {31'd0, out_valid}, 32'd0);
      check("lat_e0_count", {29'd0, fifo_count}, 32'd1);
      step();
      check("lat_e1_valid", {31'd0, out_valid}, 32'd1);
      check("lat_e1_data", {24'd0, out_data}, 32'h1E);
      check("lat_e1_lr", {31'd0, out_lr}, 32'd0);
      step();
      check("lat_e2_valid", {31'd0, out_valid}, 32'd0);

      // Left shift.
      send(8'h0F, 3'd3, 1'b1);
      step();
      check("left_valid", {31'd0, out_valid}, 32'd1);
      check("left_data", {24'd0, out_data}, 32'h78);
      check("left_lr", {31'd0, out_lr}, 32'd1);
      step();

      // Backpressure and fill.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(8'h01 << i, 3'(i), i[0]);
      end
      check("bp_count", {29'd0, fifo_count}, 32'd4);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data", {24'd0, out_data}, {24'd0, rot(8'h01, 3'd0, 1'b0)});
      step();
      check("bp_stable", {24'd0, out_data}, {24'd0, rot(8'h01, 3'd0, 1'b0)});
      out_ready = 1'b1;
      step();
      check("bp_ready_back", {31'd0, in_ready}, 32'd1);
      check("bp_count_dec", {29'd0, fifo_count}, 32'd3);
      for (int i = 0; i < 6; i++) step();
      check("bp_drained", sb.size(), 32'd0);

      // Streaming with pointer wrap.
      for (int i = 0; i < 10; i++) begin
         send(8'hF0, 3'(i % 8), i[0]);
         check("wrap_count", {31'd0, fifo_count <= 3'd1}, 32'd1);
      end
      for (int i = 0; i < 4; i++) step();
      check("wrap_drained", sb.size(), 32'd0);
      check("wrap_idle", {31'd0, out_valid}, 32'd0);

      // Mid-stream reset.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(8'h3C, 3'(i + 1), 1'b1);
      end
      check("mr_count", {29'd0, fifo_count}, 32'd3);
      check("mr_valid", {31'd0, out_valid}, 32'd1);
      reset_n = 1'b0;
      step();
      check("mr_count0", {29'd0, fifo_count}, 32'd0);
      check("mr_valid0", {31'd0, out_valid}, 32'd0);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("mr_no_stale", {31'd0, out_valid}, 32'd0);
      end
      check("mr_sb_empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
